// File: rtl/mio_bus_pkg.sv
// Shared types and constants for the MIO bus controller and its tag decoder.
package mio_bus_pkg;

   localparam int          TAG_W       = 4;
   localparam logic [31:0] DEF_SLV_TAG = 32'hFEDC_BA98;
   localparam logic [63:0] ERR_RDATA   = 64'h0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU data port plus slave-side bus; master = controller view, slave = CPU/slave-side view.
interface mio_bus_ctrl_if #(
   parameter int N_SLV = 8,
   parameter int DW    = 32,
   parameter int AW    = 19
);
   logic                cpu_req;
   logic                cpu_we;
   logic [31:0]         cpu_addr;
   logic [DW-1:0]       cpu_wdata;
   logic                cpu_ack;
   logic [DW-1:0]       cpu_rdata;
   logic                cpu_err;
   logic [N_SLV-1:0]    slv_sel;
   logic                slv_we;
   logic [AW-1:0]       slv_addr;
   logic [DW-1:0]       slv_wdata;
   logic [N_SLV*DW-1:0] slv_rdata;
   logic [N_SLV-1:0]    slv_rdy;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_rdy,
      output cpu_ack, cpu_rdata, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_rdy,
      input  cpu_ack, cpu_rdata, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
   );
endinterface

// File: rtl/mio_addr_dec.sv
// Combinational priority tag decoder: addr[31:28] vs per-slave tag table, lowest index wins.
module mio_addr_dec
   import mio_bus_pkg::*;
#(
   parameter int                       N_SLV   = 8,
   parameter logic [TAG_W*N_SLV-1:0]   SLV_TAG = (TAG_W*N_SLV)'(DEF_SLV_TAG)
) (
   input  logic [TAG_W-1:0] tag_i,
   output logic [N_SLV-1:0] hit_o,
   output logic             miss_o
);

   logic found;

   always_comb begin
      hit_o = '0;
      found = 1'b0;
      for (int i = 0; i < N_SLV; i++) begin
         if (!found && (SLV_TAG[TAG_W*i +: TAG_W] == tag_i)) begin
            hit_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
      miss_o = !found;
   end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Registered request/ack bridge from CPU data port to N tagged slaves; ack 2 cycles after request
// for a zero-wait slave, 1 for a miss; slave waits stretch ACCESS. Optional MIO_TIMEOUT_EN bounds waits.
module mio_bus_ctrl
   import mio_bus_pkg::*;
#(
   parameter int                       N_SLV   = 8,
   parameter int                       DW      = 32,
   parameter int                       AW      = 19,
   parameter logic [TAG_W*N_SLV-1:0]   SLV_TAG = (TAG_W*N_SLV)'(DEF_SLV_TAG),
   parameter int                       TO_CYC  = 255
) (
   input  logic          clk,
   input  logic          rst,
   mio_bus_ctrl_if.master bus
);

   localparam logic [7:0] TO_LIM = 8'(TO_CYC);

   state_e           state_q, state_d;
   logic [N_SLV-1:0] sel_q;
   logic             we_q;
   logic [AW-1:0]    addr_q;
   logic [DW-1:0]    wdata_q;
   logic [DW-1:0]    rdata_q;
   logic             err_q;

   logic [N_SLV-1:0] dec_hit;
   logic             dec_miss;
   logic             rdy_sel;
   logic             to_hit;
   logic [DW-1:0]    sel_rdata;

   mio_addr_dec #(
      .N_SLV   (N_SLV),
      .SLV_TAG (SLV_TAG)
   ) u_dec (
      .tag_i  (bus.cpu_addr[31:28]),
      .hit_o  (dec_hit),
      .miss_o (dec_miss)
   );

   // Only the selected slave's ready counts; sel_q is zero outside ACCESS.
   assign rdy_sel = |(bus.slv_rdy & sel_q);

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (sel_q[i]) begin
            sel_rdata = sel_rdata | bus.slv_rdata[DW*i +: DW];
         end
      end
   end

`ifdef MIO_TIMEOUT_EN
   logic [7:0] to_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_q <= '0;
      end else if (state_q == ST_IDLE) begin
         to_q <= '0;
      end else if (state_q == ST_ACCESS && !rdy_sel) begin
         to_q <= to_q + 8'd1;
      end
   end

   // Fires on the ACCESS cycle whose count reaches the limit; ready in that cycle still wins.
   assign to_hit = (state_q == ST_ACCESS) && !rdy_sel && ((to_q + 8'd1) == TO_LIM);
`else
   logic [7:0] unused_to_lim;
   assign unused_to_lim = TO_LIM;
   assign to_hit        = 1'b0;
`endif

   logic unused_addr;
   assign unused_addr = ^bus.cpu_addr[27:AW];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.cpu_req) begin
               state_d = dec_miss ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (rdy_sel || to_hit) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
               if (bus.cpu_req) begin
                  if (dec_miss) begin
                     sel_q   <= '0;
                     we_q    <= 1'b0;
                     rdata_q <= DW'(ERR_RDATA);
                     err_q   <= 1'b1;
                  end else begin
                     sel_q   <= dec_hit;
                     we_q    <= bus.cpu_we;
                     addr_q  <= bus.cpu_addr[AW-1:0];
                     wdata_q <= bus.cpu_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               if (rdy_sel) begin
                  sel_q   <= '0;
                  we_q    <= 1'b0;
                  rdata_q <= we_q ? '0 : sel_rdata;
               end else if (to_hit) begin
                  sel_q   <= '0;
                  we_q    <= 1'b0;
                  rdata_q <= DW'(ERR_RDATA);
                  err_q   <= 1'b1;
               end
            end
            default: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      bus.cpu_ack   = (state_q == ST_RESP);
      bus.cpu_rdata = rdata_q;
      bus.cpu_err   = err_q;
      bus.slv_sel   = sel_q;
      bus.slv_we    = we_q & (|sel_q);
      bus.slv_addr  = addr_q;
      bus.slv_wdata = wdata_q;
   end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: decode, wait states, miss, duplicate tags, reset, back-to-back, timeout.
module tb_mio_bus_ctrl;

   localparam int N_SLV = 8;
   localparam int DW    = 32;
   localparam int AW    = 19;
   // Slave 5 retagged to 0xA so slaves 2 and 5 collide; tag 0xD is unmapped.
   localparam logic [31:0] TAG = 32'hFEAC_BA98;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   mio_bus_ctrl_if #(.N_SLV(N_SLV), .DW(DW), .AW(AW)) bus ();

   mio_bus_ctrl #(
      .N_SLV   (N_SLV),
      .DW      (DW),
      .AW      (AW),
      .SLV_TAG (TAG),
      .TO_CYC  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.slv_rdy   = '0;
      bus.slv_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h8000_0000;
      tick();
      tick();
      checks++;
      if ({bus.cpu_ack, bus.cpu_err, bus.slv_we, bus.slv_sel} !== 11'd0) begin
         failures++;
         $display("FAIL reset_ctrl got=%h exp=0", {bus.cpu_ack, bus.cpu_err, bus.slv_we, bus.slv_sel});
      end
      checks++;
      if ({bus.cpu_rdata, bus.slv_addr, bus.slv_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0", {bus.cpu_rdata, bus.slv_addr, bus.slv_wdata});
      end
      bus.cpu_req = 1'b0;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_read_zero_wait();
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h8000_0010;
      bus.slv_rdata[DW*0 +: DW] = 32'h0000_0ABC;
      bus.slv_rdy  = 8'h01;
      tick(); // cycle 1
      checks++;
      if (bus.slv_sel !== 8'h01 || bus.slv_addr !== 19'h00010 || bus.slv_we !== 1'b0 || bus.cpu_ack !== 1'b0) begin
         failures++;
         $display("FAIL rd_c1 sel=%h addr=%h we=%b ack=%b exp sel=01 addr=00010 we=0 ack=0",
                  bus.slv_sel, bus.slv_addr, bus.slv_we, bus.cpu_ack);
      end
      tick(); // cycle 2
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h0000_0ABC || bus.cpu_err !== 1'b0 || bus.slv_sel !== 8'h00) begin
         failures++;
         $display("FAIL rd_ack ack=%b rdata=%h err=%b sel=%h exp ack=1 rdata=00000abc err=0 sel=00",
                  bus.cpu_ack, bus.cpu_rdata, bus.cpu_err, bus.slv_sel);
      end
      bus.cpu_req = 1'b0;
      tick(); // cycle 3
      checks++;
      if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 32'h0 || bus.cpu_err !== 1'b0) begin
         failures++;
         $display("FAIL rd_clear ack=%b rdata=%h err=%b exp all 0", bus.cpu_ack, bus.cpu_rdata, bus.cpu_err);
      end
      idle_inputs();
   endtask

   task automatic test_write_wait();
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 32'hF000_0004;
      bus.cpu_wdata = 32'h0000_1234;
      bus.slv_rdata[DW*7 +: DW] = 32'hDEAD_BEEF;
      tick(); // cycle 1
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (bus.slv_sel !== 8'h80 || bus.slv_we !== 1'b1 || bus.slv_wdata !== 32'h1234 ||
             bus.slv_addr !== 19'h00004 || bus.cpu_ack !== 1'b0) begin
            failures++;
            $display("FAIL wr_hold c%0d sel=%h we=%b wdata=%h addr=%h ack=%b exp sel=80 we=1 wdata=1234 addr=00004 ack=0",
                     c, bus.slv_sel, bus.slv_we, bus.slv_wdata, bus.slv_addr, bus.cpu_ack);
         end
         if (c == 4) bus.slv_rdy = 8'h80;
         tick();
      end
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h0 || bus.cpu_err !== 1'b0 ||
          bus.slv_sel !== 8'h00 || bus.slv_we !== 1'b0) begin
         failures++;
         $display("FAIL wr_ack ack=%b rdata=%h err=%b sel=%h we=%b exp ack=1 rdata=0 err=0 sel=00 we=0",
                  bus.cpu_ack, bus.cpu_rdata, bus.cpu_err, bus.slv_sel, bus.slv_we);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_miss();
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h1000_0000;
      bus.slv_rdy  = 8'hFF;
      bus.slv_rdata = {N_SLV{32'h5A5A_5A5A}};
      tick(); // cycle 1
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.cpu_err !== 1'b1 || bus.cpu_rdata !== 32'h0 || bus.slv_sel !== 8'h00) begin
         failures++;
         $display("FAIL miss_ack ack=%b err=%b rdata=%h sel=%h exp ack=1 err=1 rdata=0 sel=00",
                  bus.cpu_ack, bus.cpu_err, bus.cpu_rdata, bus.slv_sel);
      end
      bus.cpu_req = 1'b0;
      tick();
      checks++;
      if (bus.cpu_ack !== 1'b0 || bus.cpu_err !== 1'b0 || bus.slv_sel !== 8'h00) begin
         failures++;
         $display("FAIL miss_clear ack=%b err=%b sel=%h exp 0 0 00", bus.cpu_ack, bus.cpu_err, bus.slv_sel);
      end
      idle_inputs();
   endtask

   task automatic test_dup_tag();
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'hA000_0100;
      bus.slv_rdata[DW*2 +: DW] = 32'h2222_2222;
      bus.slv_rdata[DW*5 +: DW] = 32'h5555_5555;
      bus.slv_rdy  = 8'h20;
      tick(); // cycle 1
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if (bus.slv_sel !== 8'h04 || bus.cpu_ack !== 1'b0) begin
            failures++;
            $display("FAIL dup_sel c%0d sel=%h ack=%b exp sel=04 ack=0", c, bus.slv_sel, bus.cpu_ack);
         end
         bus.slv_rdy = (c == 3) ? 8'h04 : ((c == 1) ? 8'h00 : 8'h20);
         tick();
      end
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h2222_2222 || bus.cpu_err !== 1'b0) begin
         failures++;
         $display("FAIL dup_ack ack=%b rdata=%h err=%b exp ack=1 rdata=22222222 err=0",
                  bus.cpu_ack, bus.cpu_rdata, bus.cpu_err);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      int acks;
      acks = 0;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h8000_0020;
      tick(); // cycle 1, in ACCESS
      checks++;
      if (bus.slv_sel !== 8'h01) begin
         failures++;
         $display("FAIL rstm_pre sel=%h exp 01", bus.slv_sel);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.slv_sel !== 8'h00 || bus.slv_we !== 1'b0) begin
         failures++;
         $display("FAIL rstm_drop sel=%h we=%b exp 00 0", bus.slv_sel, bus.slv_we);
      end
      bus.slv_rdy = 8'h01;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus.cpu_ack) acks++;
      end
      bus.cpu_req = 1'b0;
      rst = 1'b1;
      tick();
      if (bus.cpu_ack) acks++;
      checks++;
      if (acks != 0) begin
         failures++;
         $display("FAIL rstm_noack acks=%0d exp 0", acks);
      end
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h9000_0008;
      bus.slv_rdata[DW*1 +: DW] = 32'h1111_1111;
      bus.slv_rdy  = 8'h02;
      tick();
      checks++;
      if (bus.slv_sel !== 8'h02 || bus.slv_addr !== 19'h00008) begin
         failures++;
         $display("FAIL rstm_sel sel=%h addr=%h exp 02 00008", bus.slv_sel, bus.slv_addr);
      end
      tick();
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h1111_1111 || bus.cpu_err !== 1'b0) begin
         failures++;
         $display("FAIL rstm_ack ack=%b rdata=%h err=%b exp 1 11111111 0", bus.cpu_ack, bus.cpu_rdata, bus.cpu_err);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_back_to_back();
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h8000_0040;
      bus.slv_rdata[DW*0 +: DW] = 32'h0000_0040;
      bus.slv_rdata[DW*1 +: DW] = 32'h0000_0044;
      bus.slv_rdy  = 8'h03;
      tick(); // cycle 1; address change mid-transaction must be ignored
      bus.cpu_addr = 32'h9000_0044;
      #1;
      checks++;
      if (bus.slv_sel !== 8'h01 || bus.slv_addr !== 19'h00040) begin
         failures++;
         $display("FAIL b2b_hold sel=%h addr=%h exp 01 00040", bus.slv_sel, bus.slv_addr);
      end
      tick(); // cycle 2
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h40) begin
         failures++;
         $display("FAIL b2b_ack1 ack=%b rdata=%h exp 1 00000040", bus.cpu_ack, bus.cpu_rdata);
      end
      tick(); // cycle 3, IDLE samples second request
      checks++;
      if (bus.cpu_ack !== 1'b0 || bus.slv_sel !== 8'h00) begin
         failures++;
         $display("FAIL b2b_idle ack=%b sel=%h exp 0 00", bus.cpu_ack, bus.slv_sel);
      end
      tick(); // cycle 4
      checks++;
      if (bus.slv_sel !== 8'h02 || bus.slv_addr !== 19'h00044) begin
         failures++;
         $display("FAIL b2b_sel2 sel=%h addr=%h exp 02 00044", bus.slv_sel, bus.slv_addr);
      end
      tick(); // cycle 5
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h44) begin
         failures++;
         $display("FAIL b2b_ack2 ack=%b rdata=%h exp 1 00000044", bus.cpu_ack, bus.cpu_rdata);
      end
      idle_inputs();
      tick();
   endtask

`ifdef MIO_TIMEOUT_EN
   task automatic test_timeout();
      for (int pass = 0; pass < 2; pass++) begin
         bus.cpu_req  = 1'b1;
         bus.cpu_addr = 32'h8000_0000;
         bus.slv_rdata[DW*0 +: DW] = 32'hCAFE_0001;
         bus.slv_rdy  = 8'h00;
         tick();
         for (int c = 1; c <= 4; c++) begin
            checks++;
            if (bus.slv_sel !== 8'h01 || bus.cpu_ack !== 1'b0) begin
               failures++;
               $display("FAIL to_wait p%0d c%0d sel=%h ack=%b exp 01 0", pass, c, bus.slv_sel, bus.cpu_ack);
            end
            if (c == 4 && pass == 1) bus.slv_rdy = 8'h01;
            tick();
         end
         checks++;
         if (bus.cpu_ack !== 1'b1 || bus.cpu_err !== (pass == 0) ||
             bus.cpu_rdata !== ((pass == 0) ? 32'h0 : 32'hCAFE_0001) || bus.slv_sel !== 8'h00) begin
            failures++;
            $display("FAIL to_ack p%0d ack=%b err=%b rdata=%h sel=%h exp ack=1 err=%b rdata=%h sel=00",
                     pass, bus.cpu_ack, bus.cpu_err, bus.cpu_rdata, bus.slv_sel,
                     (pass == 0), ((pass == 0) ? 32'h0 : 32'hCAFE_0001));
         end
         idle_inputs();
         tick();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_read_zero_wait();
      test_write_wait();
      test_miss();
      test_dup_tag();
      test_reset_mid();
      test_back_to_back();
`ifdef MIO_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
Parametrised successor to the single-cycle MIO address decoder, sitting between the CPU data port and N memory-mapped slaves (RAM, GPIO, counter, VGA, PS/2, sprite ROMs).
- Decodes addr[31:28] against a per-slave tag table.
- Runs a registered request/ack transaction with variable slave latency via per-slave ready.
- Captures read data into a response register.
- Flags unmapped accesses (and optionally timeouts) as bus errors.

Parameters:
N_SLV, 8, number of slave channels (1..16)
DW, 32, data width
AW, 19, slave-side address width (addr_bus[AW-1:0] forwarded)
SLV_TAG, 32'hFEDC_BA98, flattened 4-bit tags; slave i matches when addr[31:28]==SLV_TAG[4i+:4]
TO_CYC, 255, timeout limit in cycles (only used with MIO_TIMEOUT_EN); 8-bit counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
cpu_req  in  1  transaction request; held high until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  32  byte address
cpu_wdata  in  DW  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  read data, valid while cpu_ack=1
cpu_err  out  1  error flag, valid with cpu_ack
slv_sel  out  N_SLV  one-hot slave select
slv_we  out  1  write strobe, qualified by slv_sel
slv_addr  out  AW  registered cpu_addr[AW-1:0]
slv_wdata  out  DW  registered write data
slv_rdata  in  N_SLV*DW  flattened read data, slave i at [DW*i+:DW]
slv_rdy  in  N_SLV  per-slave completion; only the selected bit is honoured

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; timeout counter 0. Reset mid-transaction drops slv_sel immediately and emits no cpu_ack.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On cpu_req=1, latch addr, wdata and we; decode.
  - Multiple tag matches resolve to the lowest index.
  - Hit: next cycle slv_sel[i]=1, slv_we=cpu_we, with slv_addr/slv_wdata registered; go to ACCESS.
  - Miss: go to RESP with cpu_err=1, cpu_rdata=0; slv_sel stays 0.
- ACCESS:
  - Outputs held stable.
  - When slv_rdy[i]=1: capture slv_rdata[i] into cpu_rdata on reads (writes return 0), clear slv_sel/slv_we, go to RESP.
  - slv_rdy bits of unselected slaves are ignored.
- RESP: cpu_ack=1 for exactly one cycle, then IDLE; cpu_rdata and cpu_err clear to 0 the next cycle.
- Latency (cycle 0 = request sampled):
  - Zero-wait slave (rdy combinationally 1): cpu_ack at cycle 2.
  - Miss: cpu_ack at cycle 1.
  - Each extra wait cycle adds 1.
- Back-to-back: a new cpu_req is sampled in the IDLE cycle after RESP. Throughput is at most 1 transaction per 3 cycles.
- Changes to cpu_* while not in IDLE are ignored.
- slv_we is never asserted without a slv_sel bit.

Optional Feature:
MIO_TIMEOUT_EN
- Defined:
  - The 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without rdy.
  - On reaching TO_CYC: drop slv_sel, go to RESP with cpu_err=1, cpu_rdata=0.
  - rdy in the same cycle as the limit wins: normal completion, no error.
- Undefined: no counter; ACCESS waits indefinitely. cpu_err comes only from decode misses.

Decomposition:
- Package mio_bus_pkg:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - default tag constant
  - TAG_W=4
  - error read value
- Sub-module mio_addr_dec: combinational priority tag decoder (addr nibble, SLV_TAG -> one-hot hit vector + miss flag), instantiated once.

Test Plan:
1. Read slave 0 (tag 8, rdy tied 1): addr 0x8000_0010, slv_rdata[0]=0x0000_0ABC -> slv_sel=8'h01 at cycle 1, slv_addr=0x00010; cpu_ack at cycle 2 with rdata 0x0000_0ABC, err=0.
2. Write slave 7 (tag F) with rdy delayed 3 cycles: addr 0xF000_0004, wdata 0x1234 -> slv_we=1, slv_wdata=0x1234 for 4 cycles; ack at cycle 5, rdata 0.
3. Unmapped addr 0x1000_0000 -> slv_sel never asserted; ack at cycle 1 with err=1, rdata 0.
4. Duplicate tags (SLV_TAG slaves 2 and 5 both 0xA) -> only slv_sel[2] asserted; slv_rdy[5] pulses ignored.
5. Reset asserted during ACCESS -> slv_sel=0 in the same cycle; no ack; the next request after release completes normally.
6. MIO_TIMEOUT_EN, TO_CYC=4, rdy held 0 -> ack with err=1 after 4 ACCESS cycles; a repeat with rdy on the 4th cycle gives err=0 and data captured.
